// File: rtl/tick_period_meter_pkg.sv
// Shared types for tick_period_meter: measurement FSM state encoding and lock counter sizing.
package tick_period_meter_pkg;

    typedef enum logic [1:0] {
        TpmIdle = 2'd0,
        TpmMeas = 2'd1,
        TpmTout = 2'd2
    } tpm_state_e;

    // LOCK_N is limited to 1..15, so four bits always hold the saturating match count.
    localparam int unsigned MatchW = 4;

endpackage

// File: rtl/tick_edge_det.sv
// Rising-edge detector for the measured strobe. When TICK_SYNC_EN is defined, a 2-flop
// synchroniser sits in front of the detector.
module tick_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic tick_in,
    output logic rise
);

    logic tick_s;
    logic tick_d_q;

`ifdef TICK_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], tick_in};
        end
    end

    assign tick_s = sync_q[1];
`else
    assign tick_s = tick_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_d_q <= 1'b0;
        end else begin
            tick_d_q <= tick_s;
        end
    end

    assign rise = tick_s & ~tick_d_q;

endmodule

// File: rtl/tick_period_meter.sv
// Measures clk cycles between rising edges of tick_in, reports lock and timeout.
// Optional input synchroniser is enabled with the TICK_SYNC_EN macro.
module tick_period_meter
    import tick_period_meter_pkg::*;
#(
    parameter int unsigned CNT_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 255,
    parameter int unsigned LOCK_N      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
);

    localparam logic [CNT_W-1:0]  CntMax     = '1;
    localparam logic [CNT_W-1:0]  TimeoutVal = CNT_W'(TIMEOUT_CYC);
    localparam logic [MatchW-1:0] LockVal    = MatchW'(LOCK_N);

    logic rise;

    tick_edge_det u_edge_det (
        .clk     (clk),
        .rst     (rst),
        .tick_in (tick_in),
        .rise    (rise)
    );

    tpm_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              valid_q, valid_d;
    logic              locked_q, locked_d;
    logic              timeout_q, timeout_d;
    logic [MatchW-1:0] match_q, match_d;
    logic              have_prev_q, have_prev_d;

    logic              report;
    logic              tout_hit;
    logic              tout_clear;
    logic [MatchW-1:0] match_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TpmIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            TpmIdle: if (rise) state_d = TpmMeas;
            TpmMeas: if (!rise && cnt_q == TimeoutVal) state_d = TpmTout;
            TpmTout: if (rise) state_d = TpmMeas;
            default: state_d = TpmIdle;
        endcase
    end

    // Rise has priority over timeout; the first edge and the edge after a timeout have no
    // valid reference interval, so only a rise in MEAS reports a period.
    always_comb begin
        report     = (state_q == TpmMeas) && rise;
        tout_hit   = (state_q == TpmMeas) && !rise && (cnt_q == TimeoutVal);
        tout_clear = (state_q == TpmTout) && rise;
    end

    always_comb begin
        cnt_d = rise ? CNT_W'(1) : ((cnt_q == CntMax) ? cnt_q : cnt_q + CNT_W'(1));

        if (have_prev_q && (cnt_q == period_q)) begin
            match_next = (match_q >= LockVal) ? LockVal : match_q + MatchW'(1);
        end else begin
            match_next = '0;
        end

        period_d    = period_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        timeout_d   = timeout_q;
        match_d     = match_q;
        have_prev_d = have_prev_q;

        if (report) begin
            period_d    = cnt_q;
            valid_d     = 1'b1;
            match_d     = match_next;
            locked_d    = (match_next >= LockVal);
            have_prev_d = 1'b1;
        end
        if (tout_hit) begin
            timeout_d   = 1'b1;
            locked_d    = 1'b0;
            match_d     = '0;
            have_prev_d = 1'b0;
        end
        if (tout_clear) begin
            timeout_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            timeout_q   <= 1'b0;
            match_q     <= '0;
            have_prev_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            timeout_q   <= timeout_d;
            match_q     <= match_d;
            have_prev_q <= have_prev_d;
        end
    end

    assign period       = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_tick_period_meter.sv
// Scoreboard bench for tick_period_meter (CNT_W=8, TIMEOUT_CYC=20, LOCK_N=4).
module tb_tick_period_meter;

`ifdef TICK_SYNC_EN
    localparam int Lat = 2;
`else
    localparam int Lat = 0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_in = 1'b0;
    logic [7:0] period;
    logic       period_valid;
    logic       locked;
    logic       timeout;

    typedef struct {
        int unsigned per;
        int unsigned lck;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    tick_period_meter #(
        .CNT_W       (8),
        .TIMEOUT_CYC (20),
        .LOCK_N      (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .tick_in      (tick_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int unsigned act, input int unsigned req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // Raise tick_in so its rise lands `gap` cycles after the previous pulse's rise.
    task automatic pulse(input int gap);
        repeat (gap - 1) begin
            @(posedge clk);
            #1;
        end
        tick_in = 1'b1;
        @(posedge clk);
        #1;
        tick_in = 1'b0;
    endtask

    task automatic pulse_exp(input int gap, input int unsigned per, input int unsigned lck);
        exp_t e;
        e.per = per;
        e.lck = lck;
        exp_q.push_back(e);
        pulse(gap);
    endtask

    // Called right after the last rise: timeout must appear exactly 20 cycles later.
    task automatic expect_timeout(input string tag);
        repeat (19 + Lat) @(posedge clk);
        #1;
        check({tag, "_timeout_early"}, timeout, 0);
        @(posedge clk);
        #1;
        check({tag, "_timeout_set"}, timeout, 1);
        check({tag, "_locked_cleared"}, locked, 0);
    endtask

    always @(negedge clk) begin
        if (period_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_valid: got period %0d expected no report at %0t",
                         period, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("period", period, e.per);
                check("locked_at_report", locked, e.lck);
            end
        end
    end

    initial begin
        #1;
        check("rst_period", period, 0);
        check("rst_valid", period_valid, 0);
        check("rst_locked", locked, 0);
        check("rst_timeout", timeout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1-in-4 strobe, 10 edges: lock on the 5th report
        pulse(4);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 1);
        pulse_exp(4, 4, 1);
        pulse_exp(4, 4, 1);
        pulse_exp(4, 4, 1);
        pulse_exp(4, 4, 1);

        // One gap of 5 breaks lock, four further matches relock
        pulse_exp(5, 5, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 1);

        // Rise coinciding with cnt==20 reports and does not time out
        pulse_exp(20, 20, 0);
        check("coincident_no_timeout", timeout, 0);
        pulse_exp(2, 2, 0);
        pulse_exp(2, 2, 0);
        pulse_exp(2, 2, 0);
        pulse_exp(2, 2, 0);
        pulse_exp(2, 2, 1);

        // Strobe stops: timeout, then silent recovery edge, then a true period
        expect_timeout("stop");
        repeat (5) @(posedge clk);
        #1;
        pulse(3);
        check("recover_timeout_clear", timeout, 0);
        pulse_exp(4, 4, 0);
        pulse_exp(3, 3, 0);

        // Async reset mid-period
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_period", period, 0);
        check("async_rst_locked", locked, 0);
        check("async_rst_timeout", timeout, 0);
        check("async_rst_valid", period_valid, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pulse(6);
        pulse_exp(4, 4, 0);
        pulse_exp(4, 4, 0);

        // tick_in held high from reset release: one rise, no report, then timeout
        @(posedge clk);
        #1;
        rst = 1'b1;
        tick_in = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (20 + Lat) @(posedge clk);
        #1;
        check("stuck_timeout_early", timeout, 0);
        @(posedge clk);
        #1;
        check("stuck_timeout_set", timeout, 1);
        repeat (10) @(posedge clk);
        #1;
        check("stuck_timeout_sticky", timeout, 1);
        tick_in = 1'b0;

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
